// File: rtl/clock_overlay_pkg.sv
// Shared geometry constants and field encoding for the clock overlay renderer.
package clock_overlay_pkg;

  localparam int unsigned DIGIT_W     = 16;
  localparam int unsigned DIGIT_H     = 16;
  localparam int unsigned DIGIT_PITCH = 20;
  localparam int unsigned SEG_T       = 2;
  localparam int unsigned N_SLOTS     = 6;

  localparam int unsigned COLON0_X    = 37;
  localparam int unsigned COLON1_X    = 77;
  localparam int unsigned COLON_Y0    = 5;
  localparam int unsigned COLON_Y1    = 11;
  localparam int unsigned COLON_SZ    = 2;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_HOUR = 2'd1,
    FIELD_MIN  = 2'd2,
    FIELD_SEC  = 2'd3
  } field_e;

endpackage

// File: rtl/clock_overlay_renderer_glyph.sv
// Combinational seven-segment glyph: BCD value plus local cell x/y -> pixel on.
module seven_seg_glyph
  import clock_overlay_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic [3:0] lx_i,
  input  logic [3:0] ly_i,
  output logic       on_o
);

  localparam logic [3:0] THICK  = 4'(SEG_T);
  localparam logic [3:0] MID_LO = 4'(DIGIT_H / 2 - 1);
  localparam logic [3:0] MID_HI = 4'(DIGIT_H / 2 - 1 + SEG_T - 1);
  localparam logic [3:0] FAR_Y  = 4'(DIGIT_H - SEG_T);
  localparam logic [3:0] FAR_X  = 4'(DIGIT_W - SEG_T);

  logic [6:0] seg;  // {a,b,c,d,e,f,g}
  logic top_row, mid_row, bot_row, left_col, right_col, upper_half, lower_half;

  always_comb begin
    case (bcd_i)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
  end

  // Vertical bars overlap the middle bar so the corners join cleanly.
  always_comb begin
    top_row    = ly_i < THICK;
    mid_row    = (ly_i >= MID_LO) && (ly_i <= MID_HI);
    bot_row    = ly_i >= FAR_Y;
    left_col   = lx_i < THICK;
    right_col  = lx_i >= FAR_X;
    upper_half = ly_i <= MID_HI;
    lower_half = ly_i >= MID_LO;
    on_o = (seg[6] & top_row)
         | (seg[5] & right_col & upper_half)
         | (seg[4] & right_col & lower_half)
         | (seg[3] & bot_row)
         | (seg[2] & left_col & lower_half)
         | (seg[1] & left_col & upper_half)
         | (seg[0] & mid_row);
  end

endmodule

// File: rtl/clock_overlay_renderer.sv
// Two-stage pipelined VGA overlay drawing N_ROWS HH:MM:SS rows with edit blink
// and alarm background flash.
module clock_overlay_renderer
  import clock_overlay_pkg::*;
#(
  parameter int unsigned N_ROWS       = 2,
  parameter int unsigned ORIGIN_X     = 270,
  parameter int unsigned ORIGIN_Y     = 232,
  parameter int unsigned ROW_PITCH    = 30,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic [11:0] FG_NORMAL    = 12'h000,
  parameter logic [11:0] FG_SET       = 12'hF00,
  parameter logic [11:0] BG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_ALARM     = 12'hF80,
  localparam int unsigned ROW_W       = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
)(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pix_tick,
  input  logic                   video_on,
  input  logic [9:0]             pix_x,
  input  logic [9:0]             pix_y,
  input  logic [24*N_ROWS-1:0]   digits,
  input  logic                   settime,
  input  logic [ROW_W-1:0]       edit_row,
  input  logic [1:0]             edit_field,
  input  logic                   alarm_ring,
  output logic [11:0]            graph_rgb,
  output logic                   video_on_q
);

  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic             s1_vid_q, s1_hit_q, s1_colon_q;
  logic             s1_hit_d, s1_colon_d;
  logic [ROW_W-1:0] s1_row_q, s1_row_d;
  logic [2:0]       s1_slot_q, s1_slot_d;
  logic [3:0]       s1_lx_q, s1_lx_d, s1_ly_q, s1_ly_d;
  logic [10:0]      x11, y11, dx, dy;

  logic [11:0]      rgb_q, rgb_d;
  logic             vid2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d, settime_q;
  logic             frame_start;

  logic [3:0]       nibble;
  logic             glyph_on, hidden, fg;
  field_e           field;

  always_comb begin
    s1_hit_d   = 1'b0;
    s1_colon_d = 1'b0;
    s1_row_d   = '0;
    s1_slot_d  = '0;
    s1_lx_d    = '0;
    s1_ly_d    = '0;
    dy         = '0;
    x11        = {1'b0, pix_x};
    y11        = {1'b0, pix_y};
    dx         = x11 - 11'(ORIGIN_X);
    for (int unsigned r = 0; r < N_ROWS; r++) begin
      if (x11 >= 11'(ORIGIN_X) &&
          y11 >= 11'(ORIGIN_Y + ROW_PITCH * r) &&
          y11 <  11'(ORIGIN_Y + ROW_PITCH * r + DIGIT_H)) begin
        dy       = y11 - 11'(ORIGIN_Y + ROW_PITCH * r);
        s1_row_d = ROW_W'(r);
        for (int unsigned k = 0; k < N_SLOTS; k++) begin
          if (dx >= 11'(DIGIT_PITCH * k) && dx < 11'(DIGIT_PITCH * k + DIGIT_W)) begin
            s1_hit_d  = 1'b1;
            s1_slot_d = 3'(k);
            s1_lx_d   = 4'(dx - 11'(DIGIT_PITCH * k));
            s1_ly_d   = 4'(dy);
          end
        end
        if (((dx >= 11'(COLON0_X) && dx < 11'(COLON0_X + COLON_SZ)) ||
             (dx >= 11'(COLON1_X) && dx < 11'(COLON1_X + COLON_SZ))) &&
            ((dy >= 11'(COLON_Y0) && dy < 11'(COLON_Y0 + COLON_SZ)) ||
             (dy >= 11'(COLON_Y1) && dy < 11'(COLON_Y1 + COLON_SZ))))
          s1_colon_d = 1'b1;
      end
    end
  end

  always_comb begin
    nibble = '0;
    for (int unsigned r = 0; r < N_ROWS; r++)
      for (int unsigned k = 0; k < N_SLOTS; k++)
        if (s1_row_q == ROW_W'(r) && s1_slot_q == 3'(k))
          nibble = digits[24*r + 20 - 4*k +: 4];
  end

  seven_seg_glyph u_glyph (
    .bcd_i (nibble),
    .lx_i  (s1_lx_q),
    .ly_i  (s1_ly_q),
    .on_o  (glyph_on)
  );

  always_comb begin
    field  = field_e'(edit_field);
    hidden = settime && (edit_row == s1_row_q) && (32'(edit_row) < N_ROWS) &&
             (field != FIELD_NONE) && (s1_slot_q[2:1] == (edit_field - 2'd1)) &&
             phase_q;
    fg     = (s1_hit_q && glyph_on && !hidden) || s1_colon_q;
    if (!s1_vid_q)                rgb_d = '0;
    else if (fg)                  rgb_d = settime ? FG_SET : FG_NORMAL;
    else if (alarm_ring && phase_q) rgb_d = BG_ALARM;
    else                          rgb_d = BG_COLOR;
  end

  // A settime falling edge overrides the frame toggle so digits reappear at once.
  always_comb begin
    frame_start = (pix_x == '0) && (pix_y == '0);
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    if (frame_start) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (settime_q && !settime) phase_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vid_q   <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_colon_q <= 1'b0;
      s1_row_q   <= '0;
      s1_slot_q  <= '0;
      s1_lx_q    <= '0;
      s1_ly_q    <= '0;
      rgb_q      <= '0;
      vid2_q     <= 1'b0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      settime_q  <= 1'b0;
    end else if (pix_tick) begin
      s1_vid_q   <= video_on;
      s1_hit_q   <= s1_hit_d;
      s1_colon_q <= s1_colon_d;
      s1_row_q   <= s1_row_d;
      s1_slot_q  <= s1_slot_d;
      s1_lx_q    <= s1_lx_d;
      s1_ly_q    <= s1_ly_d;
      rgb_q      <= rgb_d;
      vid2_q     <= s1_vid_q;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      settime_q  <= settime;
    end
  end

  assign graph_rgb  = rgb_q;
  assign video_on_q = vid2_q;

endmodule
